irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
Interrupt arbiter and sequencer between the peripheral IRQ lines and the CPU interrupt input. It latches rising edges from up to 7 sources into a pending register and applies a software mask. It selects one eligible source by fixed or round-robin priority and presents it to the CPU as a 3-bit vector. It then runs an offer/acknowledge/end-of-interrupt handshake so that only one interrupt is in service at a time.

Parameters:
NSRC, 7, number of sources (1..7); source i maps to vector i+1, and vector 0 means none.
RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
TIMEOUT, 255, maximum number of OFFER cycles without cpu_ack before the offer is withdrawn (1..255).
MASK_RST, 7'h7F, reset value of the mask register (1 = enabled).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
src_irq  in  NSRC  peripheral request lines, edge-sensitive
mask_we  in  1  write strobe for the mask register
mask_wdata  in  NSRC  new mask value
mask  out  NSRC  current mask
pending  out  NSRC  current pending bits
cpu_irq  out  1  interrupt offer to the CPU (registered)
cpu_vec  out  3  vector of the offered or in-service source (registered)
cpu_ack  in  1  one-cycle pulse: CPU accepts the offered vector
cpu_eoi  in  1  one-cycle pulse: end of interrupt service
busy  out  1  high in the SERVICE state
timeout_flag  out  1  sticky; set on offer timeout, cleared by the next cpu_ack

Behaviour:
- Reset values: pending=0, prev_src=0, mask=MASK_RST, cpu_irq=0, cpu_vec=0, busy=0, timeout_flag=0, state=IDLE, rr_ptr=0, tmo_cnt=0.
- Edge detect: prev_src <= src_irq every cycle; the set term is src_irq & ~prev_src.
  - Because prev_src resets to 0, a line held high through reset release registers one edge.
- Pending update, per bit:
  - set on an edge;
  - cleared when that source is acknowledged;
  - if set and clear land in the same cycle, set wins.
- Mask: on mask_we, mask <= mask_wdata at the next edge. Masked bits stay pending but are not eligible.
- Eligibility: eligible = pending & mask, using registered values.
- Arbitration:
  - RR=0: lowest set index of eligible wins.
  - RR=1: search starts at rr_ptr and wraps at NSRC-1 to 0; on cpu_ack, rr_ptr <= winner+1, wrapping NSRC-1 to 0.
- FSM states: IDLE, OFFER, SERVICE.
  - IDLE: if eligible != 0, latch winner, cpu_vec <= winner+1, cpu_irq <= 1, tmo_cnt <= 0, go to OFFER. Otherwise cpu_vec=0 and cpu_irq=0.
  - OFFER: cpu_irq and cpu_vec are held stable even if the winner is masked meanwhile.
    - On cpu_ack: clear pending[winner], cpu_irq <= 0, busy <= 1, timeout_flag <= 0, go to SERVICE. cpu_vec is kept.
    - Otherwise tmo_cnt increments. When tmo_cnt reaches TIMEOUT-1 without ack: cpu_irq <= 0, cpu_vec <= 0, timeout_flag <= 1, go to IDLE. Pending is retained and arbitration is re-run.
  - SERVICE: on cpu_eoi, busy <= 0, cpu_vec <= 0, go to IDLE. New edges keep accumulating in pending.
- Stray handshakes: cpu_ack outside OFFER and cpu_eoi outside SERVICE are ignored. If ack and eoi arrive together in OFFER, only the ack is honoured.
- Latency:
  - A rising edge sampled at clock edge k sets pending at k. In IDLE, cpu_irq is high after edge k+1.
  - After an eoi at edge m, the next offer (if eligible) comes after edge m+1.
- Re-trigger: a source firing again while in service re-pends once; multiple edges before grant collapse into one pending bit.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); an in-flight offer or service is discarded.

Test Plan:
- Pulse src_irq[2] for one cycle in IDLE -> pending=3'b100 the next cycle; cpu_irq=1 and cpu_vec=3 two edges after the pulse; ack gives busy=1 and pending=0; eoi gives busy=0 and cpu_vec=0.
- RR=0, rising edges on sources 4, 1 and 6 in the same cycle -> vectors served in order 2, 5, 7, each after ack+eoi.
- RR=1, sources 0 and 1 kept re-firing every service -> grants alternate vec 1, 2, 1, 2.
- mask_wdata=7'h7E, pulse source 0 -> pending[0]=1, no offer. Then unmask -> offer vec 1 on the second edge after the mask write.
- TIMEOUT=4, offer with no ack -> cpu_irq drops after 4 OFFER cycles, timeout_flag=1, pending kept, re-offered next cycle. A subsequent ack clears timeout_flag.
- During SERVICE, pulse src 3 and assert rst mid-OFFER -> all outputs return to reset values asynchronously. Also: an edge on the acked source in the same cycle as its ack leaves pending=1.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-latched interrupt arbiter with offer/ack/eoi sequencing to the CPU
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   src_irq[NSRC]              edge-sensitive peripheral requests
//   mask_we, mask_wdata        mask register write port; mask reflects current value
//   pending                    latched requests awaiting grant
//   cpu_irq, cpu_vec           registered offer and vector (source i -> vector i+1, 0 = none)
//   cpu_ack, cpu_eoi           CPU accept pulse and end-of-interrupt pulse
//   busy                       high while an interrupt is in service
//   timeout_flag               sticky offer-timeout indicator, cleared by the next ack
module irq_arbiter #(
  parameter int NSRC = 7,
  parameter int RR = 0,
  parameter int TIMEOUT = 255,
  parameter logic [6:0] MASK_RST = 7'h7F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] pending,
  output logic            cpu_irq,
  output logic [2:0]      cpu_vec,
  input  logic            cpu_ack,
  input  logic            cpu_eoi,
  output logic            busy,
  output logic            timeout_flag
);
  typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;
  state_t state;
  logic [NSRC-1:0] prev_src, eligible, set_bits, clr_bits;
  logic [2:0] winner, winner_q, rr_ptr, base, idx;
  logic [7:0] tmo_cnt;
  logic ack_ok;
  assign eligible = pending & mask;
  assign set_bits = src_irq & ~prev_src;
  assign ack_ok = state == OFFER && cpu_ack;
  assign clr_bits = ack_ok ? NSRC'(1'b1) << winner_q : '0;
  assign base = RR != 0 ? rr_ptr : 3'd0;
  // Scan from the highest offset down so the last hit is the one nearest the search base.
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = 3'((int'(base) + k) % NSRC);
      if (eligible[idx]) winner = idx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prev_src <= '0;
      pending <= '0;
      mask <= MASK_RST[NSRC-1:0];
      cpu_irq <= 1'b0;
      cpu_vec <= '0;
      busy <= 1'b0;
      timeout_flag <= 1'b0;
      rr_ptr <= '0;
      tmo_cnt <= '0;
      winner_q <= '0;
    end else begin
      prev_src <= src_irq;
      // set term is applied last so a new edge survives a same-cycle acknowledge
      pending <= (pending & ~clr_bits) | set_bits;
      if (mask_we) mask <= mask_wdata;
      case (state)
        IDLE: if (|eligible) begin
          winner_q <= winner;
          cpu_vec <= winner + 3'd1;
          cpu_irq <= 1'b1;
          tmo_cnt <= '0;
          state <= OFFER;
        end
        OFFER: if (cpu_ack) begin
          cpu_irq <= 1'b0;
          busy <= 1'b1;
          timeout_flag <= 1'b0;
          rr_ptr <= winner_q == 3'(NSRC - 1) ? 3'd0 : winner_q + 3'd1;
          state <= SERVICE;
        end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          cpu_irq <= 1'b0;
          cpu_vec <= '0;
          timeout_flag <= 1'b1;
          state <= IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
        SERVICE: if (cpu_eoi) begin
          busy <= 1'b0;
          cpu_vec <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed checks of irq_arbiter in fixed-priority and round-robin builds
module tb_irq_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] src = '0, mask_wdata = '0, mask, pending;
  logic mask_we = 1'b0, ack = 1'b0, eoi = 1'b0, cpu_irq, busy, tflag;
  logic [2:0] cpu_vec;
  logic [6:0] src1 = '0, wdata1 = '0, mask1, pend1;
  logic mw1 = 1'b0, ack1 = 1'b0, eoi1 = 1'b0, irq1, busy1, tflag1;
  logic [2:0] vec1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_arbiter #(.NSRC(7), .RR(0), .TIMEOUT(4), .MASK_RST(7'h7F)) dut (
    .clk(clk), .rst(rst), .src_irq(src), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask(mask), .pending(pending), .cpu_irq(cpu_irq), .cpu_vec(cpu_vec),
    .cpu_ack(ack), .cpu_eoi(eoi), .busy(busy), .timeout_flag(tflag)
  );

  irq_arbiter #(.NSRC(7), .RR(1), .TIMEOUT(4), .MASK_RST(7'h7F)) dut_rr (
    .clk(clk), .rst(rst), .src_irq(src1), .mask_we(mw1), .mask_wdata(wdata1),
    .mask(mask1), .pending(pend1), .cpu_irq(irq1), .cpu_vec(vec1),
    .cpu_ack(ack1), .cpu_eoi(eoi1), .busy(busy1), .timeout_flag(tflag1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [2:0] v);
    for (int i = 0; i < 20 && !cpu_irq; i++) step();
    chk("offer_seen", cpu_irq, 1);
    chk("offer_vec", cpu_vec, v);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_busy", busy, 1);
    chk("ack_irq", cpu_irq, 0);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("eoi_busy", busy, 0);
    chk("eoi_vec", cpu_vec, 0);
  endtask

  task automatic serve_rr(input logic [2:0] v, input logic [6:0] refire);
    for (int i = 0; i < 20 && !irq1; i++) step();
    chk("rr_offer_seen", irq1, 1);
    chk("rr_vec", vec1, v);
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    chk("rr_busy", busy1, 1);
    src1 = refire;
    step();
    src1 = '0;
    eoi1 = 1'b1;
    step();
    eoi1 = 1'b0;
    chk("rr_eoi_busy", busy1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("rst_irq", cpu_irq, 0);
    chk("rst_vec", cpu_vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mask", mask, 7'h7F);
    chk("rst_tflag", tflag, 0);
    rst = 1'b0;
    step();
    // single pulse on source 2
    src = 7'b0000100;
    step();
    src = '0;
    chk("p1_pending", pending, 7'b0000100);
    chk("p1_no_irq_yet", cpu_irq, 0);
    step();
    chk("p1_irq", cpu_irq, 1);
    chk("p1_vec", cpu_vec, 3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("p1_busy", busy, 1);
    chk("p1_pend_clr", pending, 0);
    chk("p1_vec_kept", cpu_vec, 3);
    chk("p1_irq_drop", cpu_irq, 0);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("p1_eoi_busy", busy, 0);
    chk("p1_eoi_vec", cpu_vec, 0);
    // simultaneous edges on 1, 4, 6 served in fixed priority order
    src = 7'b1010010;
    step();
    src = '0;
    chk("p2_pending", pending, 7'b1010010);
    serve(2);
    serve(5);
    serve(7);
    chk("p2_pend_empty", pending, 0);
    // masked source stays pending without offer
    mask_we = 1'b1;
    mask_wdata = 7'h7E;
    step();
    mask_we = 1'b0;
    chk("m_mask", mask, 7'h7E);
    src = 7'b0000001;
    step();
    src = '0;
    step();
    step();
    chk("m_pending", pending, 1);
    chk("m_no_offer", cpu_irq, 0);
    mask_we = 1'b1;
    mask_wdata = 7'h7F;
    step();
    mask_we = 1'b0;
    chk("m_first_edge", cpu_irq, 0);
    step();
    chk("m_offer", cpu_irq, 1);
    chk("m_vec", cpu_vec, 1);
    // no ack: offer withdrawn after four OFFER cycles
    step();
    step();
    step();
    chk("t_still", cpu_irq, 1);
    step();
    chk("t_irq_drop", cpu_irq, 0);
    chk("t_vec_clr", cpu_vec, 0);
    chk("t_flag", tflag, 1);
    chk("t_pend_kept", pending, 1);
    step();
    chk("t_reoffer", cpu_irq, 1);
    chk("t_reoffer_vec", cpu_vec, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t_flag_clr", tflag, 0);
    chk("t_busy", busy, 1);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    // edge on the acked source in the same cycle as its ack
    src = 7'b0000001;
    step();
    src = '0;
    step();
    chk("s_offer", cpu_irq, 1);
    ack = 1'b1;
    src = 7'b0000001;
    step();
    ack = 1'b0;
    src = '0;
    chk("s_set_wins", pending, 1);
    chk("s_busy", busy, 1);
    src = 7'b0001000;
    step();
    src = '0;
    chk("s_accum", pending, 7'b0001001);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("s_stray_ack_busy", busy, 1);
    chk("s_stray_ack_pend", pending, 7'b0001001);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("s_eoi", busy, 0);
    step();
    chk("s_next_offer", cpu_irq, 1);
    chk("s_next_vec", cpu_vec, 1);
    // masking the offered winner does not disturb the offer
    mask_we = 1'b1;
    mask_wdata = 7'h00;
    step();
    mask_we = 1'b0;
    chk("h_mask", mask, 0);
    chk("h_irq_held", cpu_irq, 1);
    chk("h_vec_held", cpu_vec, 1);
    // asynchronous reset mid-offer
    #2 rst = 1'b1;
    #1;
    chk("ar_irq", cpu_irq, 0);
    chk("ar_vec", cpu_vec, 0);
    chk("ar_pending", pending, 0);
    chk("ar_busy", busy, 0);
    chk("ar_mask", mask, 7'h7F);
    step();
    rst = 1'b0;
    step();
    // round-robin alternation between sources 0 and 1
    src1 = 7'b0000011;
    step();
    src1 = '0;
    chk("rr_pending", pend1, 7'b0000011);
    serve_rr(1, 7'b0000001);
    serve_rr(2, 7'b0000010);
    serve_rr(1, 7'b0000001);
    serve_rr(2, 7'b0000000);
    chk("rr_left", pend1, 7'b0000001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
